// File: rtl/pwm3_pkg.sv
// Register map, control/status bit positions and channel count for the
// three-channel PWM host register block.
package pwm3_pkg;

    typedef enum logic [2:0] {
        ADDR_CTRL     = 3'd0,
        ADDR_PRESCALE = 3'd1,
        ADDR_PERIOD   = 3'd2,
        ADDR_DUTY0    = 3'd3,
        ADDR_DUTY1    = 3'd4,
        ADDR_DUTY2    = 3'd5,
        ADDR_STATUS   = 3'd6,
        ADDR_COUNT    = 3'd7
    } regAddr_e;

    localparam int NUM_CH       = 3;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_INV_LSB = 1;
    localparam int STATUS_RUN   = 0;
    localparam int STATUS_PEND  = 1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register loaded from its shadow, counter
// compare, polarity select and registered output.
module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             inv_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             pwm_o
);

    logic [CNT_W-1:0] dutyAct_q;
    logic             pwm_q;
    logic             pwm_d;

    // A duty of zero never compares true and a duty above the period always
    // does, which gives the constant-low and constant-high cases for free.
    always_comb begin
        pwm_d = inv_i;
        if (en_i) begin
            pwm_d = (cnt_i < dutyAct_q) ^ inv_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dutyAct_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            if (load_i) begin
                dutyAct_q <= duty_i;
            end
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm3_host_regs.sv
// Host-bus register responder plus the shared prescaler and period counter
// driving three double-buffered PWM channels.
module pwm3_host_regs
    import pwm3_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              host_clk,
    input  logic              host_rst,
    input  logic              host_cs,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [CNT_W-1:0]  host_wdata,
    output logic [CNT_W-1:0]  host_rdata,
    output logic              host_ack,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              pwm_sync
);

    regAddr_e           addr;
    logic               access;
    logic               wr;
    logic               rd;
    logic               shadowWr;
    logic               tick;
    logic               wrap;
    logic               load;

    logic               ack_q;
    logic [CNT_W-1:0]   rdata_q;
    logic [CNT_W-1:0]   rdata_d;
    logic               en_q;
    logic [NUM_CH-1:0]  inv_q;
    logic [CNT_W-1:0]   prescale_q;
    logic [CNT_W-1:0]   periodSh_q;
    logic [CNT_W-1:0]   periodAct_q;
    logic [CNT_W-1:0]   dutySh_q [NUM_CH];
    logic               pending_q;
    logic [CNT_W-1:0]   preCnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sync_q;

    assign addr     = regAddr_e'(host_addr);
    // The ack cycle masks the request so a held host_cs cannot retrigger.
    assign access   = host_cs & ~ack_q;
    assign wr       = access & host_we;
    assign rd       = access & ~host_we;
    assign shadowWr = wr & (addr inside {ADDR_PERIOD, ADDR_DUTY0, ADDR_DUTY1, ADDR_DUTY2});
    // >= keeps the prescaler from running the long way round when PRESCALE is lowered mid-count.
    assign tick     = en_q & (preCnt_q >= prescale_q);
    assign wrap     = tick & (cnt_q == periodAct_q);
    assign load     = ~en_q | wrap;

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            case (addr)
                ADDR_CTRL: begin
                    rdata_d[CTRL_EN]                = en_q;
                    rdata_d[CTRL_INV_LSB +: NUM_CH] = inv_q;
                end
                ADDR_PRESCALE: rdata_d = prescale_q;
                ADDR_PERIOD:   rdata_d = periodSh_q;
                ADDR_DUTY0:    rdata_d = dutySh_q[0];
                ADDR_DUTY1:    rdata_d = dutySh_q[1];
                ADDR_DUTY2:    rdata_d = dutySh_q[2];
                ADDR_STATUS: begin
                    rdata_d[STATUS_RUN]  = en_q;
                    rdata_d[STATUS_PEND] = pending_q;
                end
                ADDR_COUNT:    rdata_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            en_q       <= 1'b0;
            inv_q      <= '0;
            prescale_q <= '0;
            periodSh_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dutySh_q[i] <= '0;
            end
        end else begin
            ack_q   <= access;
            rdata_q <= rdata_d;
            if (wr) begin
                case (addr)
                    ADDR_CTRL: begin
                        en_q  <= host_wdata[CTRL_EN];
                        inv_q <= host_wdata[CTRL_INV_LSB +: NUM_CH];
                    end
                    ADDR_PRESCALE: prescale_q  <= host_wdata;
                    ADDR_PERIOD:   periodSh_q  <= host_wdata;
                    ADDR_DUTY0:    dutySh_q[0] <= host_wdata;
                    ADDR_DUTY1:    dutySh_q[1] <= host_wdata;
                    ADDR_DUTY2:    dutySh_q[2] <= host_wdata;
                    default: ;
                endcase
            end
        end
    end

    // A shadow write landing on the wrap edge keeps pending set; the wrap
    // itself transfers the pre-write shadow value.
    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            preCnt_q    <= '0;
            cnt_q       <= '0;
            periodAct_q <= '0;
            pending_q   <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            sync_q <= wrap;
            if (!en_q) begin
                preCnt_q <= '0;
                cnt_q    <= '0;
            end else begin
                preCnt_q <= tick ? '0 : preCnt_q + 1'b1;
                if (tick) begin
                    cnt_q <= wrap ? '0 : cnt_q + 1'b1;
                end
            end
            if (load) begin
                periodAct_q <= periodSh_q;
            end
            if (!en_q) begin
                pending_q <= 1'b0;
            end else if (shadowWr) begin
                pending_q <= 1'b1;
            end else if (wrap) begin
                pending_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i  (host_clk),
            .rst_i  (host_rst),
            .en_i   (en_q),
            .inv_i  (inv_q[g]),
            .load_i (load),
            .duty_i (dutySh_q[g]),
            .cnt_i  (cnt_q),
            .pwm_o  (pwm_out[g])
        );
    end

    assign host_ack   = ack_q;
    assign host_rdata = rdata_q;
    assign pwm_sync   = sync_q;

endmodule

// File: tb/tb_pwm3_host_regs.sv
// Self-checking bench for pwm3_host_regs: register table through a read
// scoreboard, then hand-written waveform sequences against an analytic model.
module tb_pwm3_host_regs;

    logic        host_clk = 1'b0;
    logic        host_rst;
    logic        host_cs;
    logic        host_we;
    logic [2:0]  host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        host_ack;
    logic [2:0]  pwm_out;
    logic        pwm_sync;

    int checks = 0;
    int errors = 0;

    logic [15:0] expQ [$];

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] expRd;
    } vec_t;

    vec_t vecs [$];

    pwm3_host_regs #(
        .CNT_W  (16),
        .ADDR_W (3)
    ) dut (
        .host_clk   (host_clk),
        .host_rst   (host_rst),
        .host_cs    (host_cs),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .pwm_out    (pwm_out),
        .pwm_sync   (pwm_sync)
    );

    always #5 host_clk = ~host_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic we, input logic [2:0] addr,
                                   input logic [15:0] wdata, input logic [15:0] expRd);
        vec_t v;
        v.we    = we;
        v.addr  = addr;
        v.wdata = wdata;
        v.expRd = expRd;
        return v;
    endfunction

    // One bus access; returns on the negedge where ack is visible.
    task automatic applyStimulus(input logic we, input logic [2:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] expRd);
        int          waitCyc;
        logic [15:0] expVal;
        if (host_ack) @(negedge host_clk);
        host_cs    = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        if (!we) expQ.push_back(expRd);
        waitCyc = 0;
        do begin
            @(negedge host_clk);
            waitCyc++;
        end while (!host_ack && waitCyc < 8);
        host_cs = 1'b0;
        host_we = 1'b0;
        checkOutput($sformatf("ackLatency addr%0d", addr), 16'(waitCyc), 16'd1);
        if (!we) begin
            expVal = expQ.pop_front();
            if (host_ack) checkOutput($sformatf("rdata addr%0d", addr), host_rdata, expVal);
        end
    endtask

    task automatic nextSync();
        int n = 0;
        @(negedge host_clk);
        while (!pwm_sync && n < 64) begin
            @(negedge host_clk);
            n++;
        end
        checkOutput("syncWait", 16'(pwm_sync), 16'd1);
    endtask

    // k = cycles since the pwm_sync cycle; outputs then reflect counter phase k-1.
    task automatic checkWave(input int startK, input int n, input int pre, input int per,
                             input int d0, input int d1, input int d2, input logic [2:0] inv);
        int         len;
        int         k;
        int         c;
        logic [2:0] expPwm;
        len = (per + 1) * (pre + 1);
        for (int i = 0; i < n; i++) begin
            k = (startK + i) % len;
            c = ((k + len - 1) % len) / (pre + 1);
            expPwm = {(c < d2), (c < d1), (c < d0)} ^ inv;
            checkOutput($sformatf("pwm_out k=%0d", k), 16'(pwm_out), 16'(expPwm));
            checkOutput($sformatf("pwm_sync k=%0d", k), 16'(pwm_sync), 16'(k == 0));
            @(negedge host_clk);
        end
    endtask

    initial begin
        host_rst   = 1'b1;
        host_cs    = 1'b0;
        host_we    = 1'b0;
        host_addr  = 3'd0;
        host_wdata = 16'h0;

        for (int a = 0; a < 8; a++) vecs.push_back(mkVec(1'b0, 3'(a), 16'h0, 16'h0));
        vecs.push_back(mkVec(1'b1, 3'd0, 16'hFFF0, 16'h0));
        vecs.push_back(mkVec(1'b0, 3'd0, 16'h0,    16'h0));
        vecs.push_back(mkVec(1'b1, 3'd6, 16'hFFFF, 16'h0));
        vecs.push_back(mkVec(1'b1, 3'd7, 16'hFFFF, 16'h0));
        vecs.push_back(mkVec(1'b0, 3'd6, 16'h0,    16'h0));
        vecs.push_back(mkVec(1'b0, 3'd7, 16'h0,    16'h0));
        vecs.push_back(mkVec(1'b1, 3'd1, 16'h1234, 16'h0));
        vecs.push_back(mkVec(1'b0, 3'd1, 16'h0,    16'h1234));
        vecs.push_back(mkVec(1'b1, 3'd1, 16'd0,    16'h0));
        vecs.push_back(mkVec(1'b1, 3'd2, 16'd9,    16'h0));
        vecs.push_back(mkVec(1'b1, 3'd3, 16'd3,    16'h0));
        vecs.push_back(mkVec(1'b1, 3'd4, 16'd0,    16'h0));
        vecs.push_back(mkVec(1'b1, 3'd5, 16'd15,   16'h0));
        vecs.push_back(mkVec(1'b0, 3'd1, 16'h0,    16'd0));
        vecs.push_back(mkVec(1'b0, 3'd2, 16'h0,    16'd9));
        vecs.push_back(mkVec(1'b0, 3'd3, 16'h0,    16'd3));
        vecs.push_back(mkVec(1'b0, 3'd4, 16'h0,    16'd0));
        vecs.push_back(mkVec(1'b0, 3'd5, 16'h0,    16'd15));
        vecs.push_back(mkVec(1'b0, 3'd6, 16'h0,    16'h0));
        vecs.push_back(mkVec(1'b1, 3'd0, 16'h0001, 16'h0));
        vecs.push_back(mkVec(1'b0, 3'd0, 16'h0,    16'h0001));
        vecs.push_back(mkVec(1'b0, 3'd6, 16'h0,    16'h0001));

        repeat (3) @(negedge host_clk);
        checkOutput("reset ack",   16'(host_ack), 16'd0);
        checkOutput("reset rdata", host_rdata,    16'd0);
        checkOutput("reset pwm",   16'(pwm_out),  16'd0);
        checkOutput("reset sync",  16'(pwm_sync), 16'd0);
        host_rst = 1'b0;
        @(negedge host_clk);

        foreach (vecs[i]) applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expRd);

        // Basic waveform: ch0 3/10, ch1 low, ch2 high.
        nextSync();
        checkWave(0, 20, 0, 9, 3, 0, 15, 3'b000);

        // Inversion with EN low, then running.
        applyStimulus(1'b1, 3'd0, 16'h000A, 16'h0);
        @(negedge host_clk);
        checkOutput("inv idle pwm", 16'(pwm_out), 16'b101);
        applyStimulus(1'b0, 3'd7, 16'h0, 16'h0);
        applyStimulus(1'b1, 3'd0, 16'h000B, 16'h0);
        nextSync();
        checkWave(0, 20, 0, 9, 3, 0, 15, 3'b101);

        // Mid-period duty update.
        applyStimulus(1'b1, 3'd0, 16'h0001, 16'h0);
        nextSync();
        applyStimulus(1'b1, 3'd3, 16'd7, 16'h0);
        applyStimulus(1'b0, 3'd6, 16'h0, 16'h0003);
        checkWave(3, 7, 0, 9, 3, 0, 15, 3'b000);
        checkWave(0, 10, 0, 9, 7, 0, 15, 3'b000);
        applyStimulus(1'b0, 3'd6, 16'h0, 16'h0001);

        // Duty write sampled on the wrap edge itself.
        checkWave(1, 8, 0, 9, 7, 0, 15, 3'b000);
        applyStimulus(1'b1, 3'd3, 16'd2, 16'h0);
        checkOutput("wrapEdge sync", 16'(pwm_sync), 16'd1);
        applyStimulus(1'b0, 3'd6, 16'h0, 16'h0003);
        checkWave(2, 8, 0, 9, 7, 0, 15, 3'b000);
        checkWave(0, 10, 0, 9, 2, 0, 15, 3'b000);
        applyStimulus(1'b0, 3'd6, 16'h0, 16'h0001);

        // Prescaled period, then EN cleared mid-period.
        applyStimulus(1'b1, 3'd1, 16'd2, 16'h0);
        applyStimulus(1'b1, 3'd2, 16'd3, 16'h0);
        nextSync();
        nextSync();
        checkWave(0, 24, 2, 3, 2, 0, 15, 3'b000);
        checkWave(0, 5, 2, 3, 2, 0, 15, 3'b000);
        applyStimulus(1'b1, 3'd0, 16'h000E, 16'h0);
        @(negedge host_clk);
        checkOutput("disable pwm",  16'(pwm_out),  16'b111);
        checkOutput("disable sync", 16'(pwm_sync), 16'd0);
        applyStimulus(1'b0, 3'd7, 16'h0, 16'h0);
        applyStimulus(1'b0, 3'd6, 16'h0, 16'h0);

        // Reset asserted on the edge that would sample a request.
        @(negedge host_clk);
        host_cs   = 1'b1;
        host_we   = 1'b0;
        host_addr = 3'd1;
        host_rst  = 1'b1;
        @(negedge host_clk);
        checkOutput("midReset ack",   16'(host_ack), 16'd0);
        checkOutput("midReset rdata", host_rdata,    16'd0);
        checkOutput("midReset pwm",   16'(pwm_out),  16'd0);
        host_cs = 1'b0;
        @(negedge host_clk);
        host_rst = 1'b0;
        @(negedge host_clk);
        applyStimulus(1'b0, 3'd0, 16'h0, 16'h0);
        applyStimulus(1'b0, 3'd1, 16'h0, 16'h0);
        applyStimulus(1'b0, 3'd3, 16'h0, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm3_host_regs.md
# pwm3_host_regs

Host-bus responder and 3-channel PWM generator on `host_clk`. Decodes single-word register accesses from the host bus initiator, holds prescaler/period/duty configuration in double-buffered registers, and drives three PWM outputs plus a period-start strobe. Sits directly below the clock/reset system controller and consumes its host clock.

## Interface
- `CNT_W`, 16, counter/duty/period/prescale/data width
- `ADDR_W`, 3, word-address width
- `host_clk` in 1: host bus clock, single clock domain
- `host_rst` in 1: reset, synchronous, active-high
- `host_cs` in 1: transaction request, held until `host_ack`
- `host_we` in 1: 1 = write, 0 = read
- `host_addr` in ADDR_W: word address
- `host_wdata` in CNT_W: write data
- `host_rdata` out CNT_W: read data, valid only while `host_ack`=1, else 0
- `host_ack` out 1: one-cycle completion pulse
- `pwm_out` out 3: PWM outputs, bit n = channel n
- `pwm_sync` out 1: one-cycle pulse at each period start

## Operation
- Register map: 0 CTRL (bit0 EN, bits3:1 INV per channel, others read 0); 1 PRESCALE; 2 PERIOD (shadow); 3/4/5 DUTY0/1/2 (shadow); 6 STATUS RO (bit0 = EN & counting, bit1 = update pending); 7 COUNT RO (active counter). Reads of CTRL/PRESCALE/PERIOD/DUTY return the written (shadow) value. Writes to RO addresses are ignored.
- Handshake: edge samples `host_cs`=1 with `host_ack`=0 → access performed at that edge; `host_ack`=1 and `host_rdata` loaded for the following cycle. `host_cs` in the ack cycle is not sampled; the next access is sampled no earlier than the edge after the ack cycle. Max throughput: one access per 2 cycles.
- Prescaler: `pre_cnt` counts 0..PRESCALE; `tick` = EN & (`pre_cnt`==PRESCALE). PRESCALE=0 → tick every cycle.
- Counter: on tick, `cnt` increments; if `cnt`==active PERIOD, `cnt`→0 (wrap), shadows copied to active, pending cleared, `pwm_sync`=1 the following cycle.
- EN=0: `pre_cnt`, `cnt` held at 0; shadows copied to active every cycle; pending reads 0. EN 0→1: counting starts from 0, first wrap after PERIOD+1 ticks.
- Compare: raw_n = (`cnt` < active DUTYn). DUTY=0 → constant low; DUTY > PERIOD → constant high. `pwm_out[n]` = EN ? raw_n ^ INV[n] : INV[n].
- Pending: set by write to PERIOD or any DUTY. Write and wrap on the same edge: wrap transfers the pre-write shadow; new value stays in shadow; pending remains 1.
- Arithmetic: all unsigned CNT_W; counter never exceeds active PERIOD.

## Timing
- Reset (`host_rst`=1 at edge): all registers, shadows, active copies, `pre_cnt`, `cnt` = 0; `host_ack`=0, `host_rdata`=0, `pwm_out`=3'b000, `pwm_sync`=0. Reset mid-transaction drops it: no ack issued.
- Access latency: ack 1 cycle after the sampling edge. Written CTRL/PRESCALE take effect from that edge.
- `pwm_out` and `pwm_sync` registered: change one cycle after the `cnt` value they reflect.
- PWM period = (PERIOD+1)·(PRESCALE+1) clocks; high time = min(DUTY, PERIOD+1)·(PRESCALE+1).

## Structure
- Package `pwm3_pkg`: address constants (ADDR_CTRL … ADDR_COUNT), CTRL bit positions (CTRL_EN, CTRL_INV_LSB), STATUS bit positions.
- Sub-module `pwm_channel` (active-duty register, compare, polarity, output flop), instantiated 3×; top holds bus decode, prescaler, counter, shadows.

## Test plan
- Reset, then read all 8 addresses → each ack 1 cycle after sample, rdata=0, `pwm_out`=000.
- PRESCALE=0, PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=15, EN=1 → ch0 high 3 of every 10 cycles, ch1 constant low, ch2 constant high, `pwm_sync` every 10 cycles.
- INV=3'b101 with EN=0 → `pwm_out`=101; EN=1 → ch0/ch2 waveforms inverted.
- Running PERIOD=9, write DUTY0=7 mid-period → STATUS bit1=1, old duty until next wrap, new duty from wrap, pending 0 after.
- Write DUTY0 on exact wrap edge → old shadow transferred, pending stays 1, new duty applied at following wrap.
- PRESCALE=2, PERIOD=3 → `pwm_sync` every 12 cycles; EN cleared mid-period → COUNT reads 0, outputs at INV level next cycle.
